rgs_prbs_checker: RTL and testbench

//   Receive-side counterpart of the RGS randomizer: consumes the serial pseudo-random bit stream,

---
 rtl/rgs_prbs_checker.sv | 171 +++++++++++++++++
 tb/tb_rgs_prbs_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgs_prbs_checker.sv
// Receive-side PRBS checker: self-synchronises a Fibonacci LFSR to the incoming
// randomized bit stream, declares lock, then counts bit errors while locked.
module rgs_prbs_checker #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter int              LOCK_GOOD = 32,
    parameter int              LOSS_ERR  = 4,
    parameter int              LOSS_WIN  = 64,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int SEED_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int ERR_W  = $clog2(LOSS_ERR + 1);
    localparam int BEAT_W = $clog2(LOSS_WIN + 1);

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(WIDTH - 1);
    localparam logic [SEED_W-1:0] SEED_ONE  = {{(SEED_W-1){1'b0}}, 1'b1};
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_LIMIT = ERR_W'(LOSS_ERR);
    localparam logic [ERR_W-1:0]  ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [BEAT_W-1:0] WIN_LIMIT = BEAT_W'(LOSS_WIN);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_sr;
    logic [SEED_W-1:0]   r_seed_cnt;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic [ERR_W-1:0]    r_win_err;
    logic [BEAT_W-1:0]   r_win_beats;
    logic                r_locked;
    logic                r_err_pulse;
    logic [CNT_W-1:0]    r_err_count;

    logic                w_pred;
    logic                w_mismatch;
    logic                w_sr_zero;
    logic [ERR_W-1:0]    w_win_err_nxt;
    logic [BEAT_W-1:0]   w_win_beats_nxt;
    logic                w_cnt_inc;

    // Next predicted bit: parity of the tapped shift-register bits.
    function automatic logic f_predict(input logic [WIDTH-1:0] sr);
        return ^(sr & TAPS);
    endfunction

    // Prediction, mismatch and the would-be loss-window counters for this beat.
    always_comb begin
        w_pred     = f_predict(r_sr);
        w_mismatch = w_pred ^ in_bit;
        w_sr_zero  = (r_sr == {WIDTH{1'b0}});
        if (w_mismatch) begin
            w_win_err_nxt = r_win_err + ERR_ONE;
        end else begin
            w_win_err_nxt = r_win_err;
        end
        // The window is open while any error is outstanding; it starts on the first error.
        if (w_mismatch || (r_win_err != {ERR_W{1'b0}})) begin
            w_win_beats_nxt = r_win_beats + BEAT_ONE;
        end else begin
            w_win_beats_nxt = {BEAT_W{1'b0}};
        end
        w_cnt_inc = in_valid && (r_state == ST_LOCKED) && w_mismatch;
    end

    // Synchronisation FSM with shift register, lock/loss counters and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEED;
            r_sr        <= {WIDTH{1'b0}};
            r_seed_cnt  <= {SEED_W{1'b0}};
            r_good_cnt  <= {GOOD_W{1'b0}};
            r_win_err   <= {ERR_W{1'b0}};
            r_win_beats <= {BEAT_W{1'b0}};
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_sr <= {r_sr[WIDTH-2:0], in_bit};
                        if (r_seed_cnt == SEED_LAST) begin
                            r_seed_cnt <= {SEED_W{1'b0}};
                            r_good_cnt <= {GOOD_W{1'b0}};
                            r_state    <= ST_VERIFY;
                        end else begin
                            r_seed_cnt <= r_seed_cnt + SEED_ONE;
                        end
                    end
                    ST_VERIFY: begin
                        r_sr <= {r_sr[WIDTH-2:0], in_bit};
                        // An all-zero register predicts zeros forever; never let it earn lock.
                        if (w_sr_zero) begin
                            r_good_cnt <= r_good_cnt;
                        end else if (w_mismatch) begin
                            r_good_cnt <= {GOOD_W{1'b0}};
                        end else if (r_good_cnt == GOOD_LAST) begin
                            r_good_cnt  <= {GOOD_W{1'b0}};
                            r_win_err   <= {ERR_W{1'b0}};
                            r_win_beats <= {BEAT_W{1'b0}};
                            r_state     <= ST_LOCKED;
                            r_locked    <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + GOOD_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel on the prediction so a single line error does not propagate.
                        r_sr        <= {r_sr[WIDTH-2:0], w_pred};
                        r_err_pulse <= w_mismatch;
                        if (w_win_err_nxt == ERR_LIMIT) begin
                            r_win_err   <= {ERR_W{1'b0}};
                            r_win_beats <= {BEAT_W{1'b0}};
                            r_seed_cnt  <= {SEED_W{1'b0}};
                            r_state     <= ST_SEED;
                            r_locked    <= 1'b0;
                        end else if (w_win_beats_nxt == WIN_LIMIT) begin
                            r_win_err   <= {ERR_W{1'b0}};
                            r_win_beats <= {BEAT_W{1'b0}};
                        end else begin
                            r_win_err   <= w_win_err_nxt;
                            r_win_beats <= w_win_beats_nxt;
                        end
                    end
                    default: begin
                        r_state    <= ST_SEED;
                        r_seed_cnt <= {SEED_W{1'b0}};
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; a clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            r_err_count <= {CNT_W{1'b0}};
        end else if (w_cnt_inc && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_ONE;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign state_o   = r_state;

endmodule

// File: tb/tb_rgs_prbs_checker.sv
// Directed and randomized bench for rgs_prbs_checker, checked against a behavioural
// model built from a bit-history queue and beat-index bookkeeping.
module tb_rgs_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked,  err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_o;
    logic        locked_s, err_pulse_s;
    logic [2:0]  err_count_s;
    logic [1:0]  state_o_s;

    rgs_prbs_checker u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_o(state_o)
    );

    // Small-counter instance so saturation is reachable in a short run.
    rgs_prbs_checker #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .state_o(state_o_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transmitter-side generator
    bit [15:0] taps_v = 16'hB400;
    bit [15:0] g;

    function automatic bit gen_bit();
        bit b;
        b = ^(g & taps_v);
        g = {g[14:0], b};
        return b;
    endfunction

    // Reference model: history queue (newest at back), mode 0/1/2, beat bookkeeping.
    bit hist[$];
    int m_mode, m_seeded, m_good, m_lbeat, m_wstart, m_werrs, m_errs;
    bit m_pulse;

    function automatic bit m_pred();
        bit p;
        p = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (taps_v[k]) p ^= hist[15-k];
        end
        return p;
    endfunction

    function automatic bit m_zero();
        bit z;
        z = 1'b1;
        foreach (hist[i]) if (hist[i]) z = 1'b0;
        return z;
    endfunction

    function automatic void m_push(input bit x);
        hist.push_back(x);
        void'(hist.pop_front());
    endfunction

    function automatic void model_step(input bit r, input bit v, input bit b, input bit c);
        bit p;
        if (r) begin
            hist.delete();
            for (int i = 0; i < 16; i++) hist.push_back(1'b0);
            m_mode = 0; m_seeded = 0; m_good = 0; m_lbeat = 0; m_wstart = 0;
            m_werrs = 0; m_errs = 0; m_pulse = 1'b0;
            return;
        end
        m_pulse = 1'b0;
        if (v) begin
            p = m_pred();
            if (m_mode == 0) begin
                m_push(b);
                m_seeded++;
                if (m_seeded == 16) begin m_mode = 1; m_seeded = 0; m_good = 0; end
            end else if (m_mode == 1) begin
                if (!m_zero()) begin
                    if (p != b) m_good = 0;
                    else m_good++;
                end
                m_push(b);
                if (m_good == 32) begin m_mode = 2; m_good = 0; m_lbeat = 0; m_werrs = 0; end
            end else begin
                m_push(p);
                m_lbeat++;
                if (p != b) begin
                    m_pulse = 1'b1;
                    m_errs++;
                    if (m_werrs == 0) m_wstart = m_lbeat;
                    m_werrs++;
                end
                if (m_werrs == 4) begin
                    m_mode = 0; m_seeded = 0; m_werrs = 0;
                end else if (m_werrs > 0 && (m_lbeat - m_wstart + 1) == 64) begin
                    m_werrs = 0;
                end
            end
        end
        if (c) m_errs = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("locked",      32'(locked),      32'(m_mode == 2));
        chk("state_o",     32'(state_o),     32'(m_mode));
        chk("err_pulse",   32'(err_pulse),   32'(m_pulse));
        chk("err_count",   32'(err_count),   (m_errs > 65535) ? 32'd65535 : 32'(m_errs));
        chk("sat_count",   32'(err_count_s), (m_errs > 7) ? 32'd7 : 32'(m_errs));
        chk("sat_locked",  32'(locked_s),    32'(m_mode == 2));
        chk("sat_state",   32'(state_o_s),   32'(m_mode));
        chk("sat_pulse",   32'(err_pulse_s), 32'(m_pulse));
    endtask

    task automatic cyc(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clr_cnt = c;
        @(posedge clk);
        model_step(rst, v, b, c);
        #1;
        check_all();
    endtask

    task automatic beat(input bit flip);
        bit b;
        b = gen_bit() ^ flip;
        cyc(1'b1, b, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic wait_lock(input string tag, input int budget);
        for (int i = 0; i < budget && !locked; i++) beat(1'b0);
        chk(tag, 32'(locked), 32'd1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, npulse, vb;
        bit v, f, c;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        g = 16'hACE1;
        idle(); idle();
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_state",  32'(state_o), 32'd0);
        chk("reset_count",  32'(err_count), 32'd0);
        rst = 1'b0;

        // 1: clean PRBS from 0xACE1
        beats = 0;
        for (int i = 0; i < 200 && !locked; i++) begin
            beat(1'b0);
            beats++;
            if (beats == 15) chk("t1_seed_at15", 32'(state_o), 32'd0);
            if (beats == 16) chk("t1_verify_at16", 32'(state_o), 32'd1);
        end
        chk("t1_lock_beats", 32'(beats), 32'd48);
        chk("t1_count", 32'(err_count), 32'd0);

        // 2: single flipped bit
        beat(1'b1);
        chk("t2_pulse", 32'(err_pulse), 32'd1);
        chk("t2_count", 32'(err_count), 32'd1);
        chk("t2_locked", 32'(locked), 32'd1);
        npulse = 0;
        for (int i = 0; i < 100; i++) begin
            beat(1'b0);
            npulse += int'(err_pulse);
        end
        chk("t2_quiet", 32'(npulse), 32'd0);
        chk("t2_still_locked", 32'(locked), 32'd1);

        // 3: four errors within 20 beats drop lock, then relock
        cyc(1'b1, gen_bit(), 1'b1);
        chk("t3_clear", 32'(err_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            beat(1'(i % 5 == 0));
            if (i == 10) chk("t3_locked_after3", 32'(locked), 32'd1);
            if (i == 15) begin
                chk("t3_unlock", 32'(locked), 32'd0);
                chk("t3_state_seed", 32'(state_o), 32'd0);
            end
        end
        beats = 4;
        for (int i = 0; i < 200 && !locked; i++) begin
            beat(1'b0);
            beats++;
        end
        chk("t3_relock_beats", 32'(beats), 32'd48);
        chk("t3_count", 32'(err_count), 32'd4);

        // 4: errors spaced 70 beats apart never fill the window
        for (int i = 0; i < 6; i++) begin
            beat(1'b1);
            chk("t4_count", 32'(err_count), 32'(5 + i));
            for (int j = 0; j < 69; j++) beat(1'b0);
            chk("t4_locked", 32'(locked), 32'd1);
        end
        chk("t4_sat", 32'(err_count_s), 32'd7);

        // 5: all-zero stream never locks
        rst = 1'b1; idle(); rst = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i >= 16) chk("t5_verify", 32'(state_o), 32'd1);
        end
        chk("t5_never_locked", 32'(locked), 32'd0);

        // 6: random gaps, random errors, clear collision, reset mid-lock
        rst = 1'b1; idle(); rst = 1'b0;
        g = 16'($urandom_range(1, 65535));
        vb = 0;
        for (int i = 0; i < 400 && vb < 52; i++) begin
            v = ($urandom_range(0, 99) < 60);
            if (v) begin vb++; beat(1'b0); end
            else idle();
            chk("t6_lock_valid_beats", 32'(locked), 32'(vb >= 48));
        end
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 99) < 70);
            f = ($urandom_range(0, 99) < 4);
            c = ($urandom_range(0, 99) < 1);
            if (v) cyc(1'b1, gen_bit() ^ f, c);
            else   cyc(1'b0, 1'($urandom_range(0, 1)), c);
        end
        wait_lock("t6_wait_lock1", 200);
        cyc(1'b1, gen_bit() ^ 1'b1, 1'b1);
        chk("t6_clr_pulse", 32'(err_pulse), 32'd1);
        chk("t6_clr_count", 32'(err_count), 32'd0);
        wait_lock("t6_wait_lock2", 200);
        rst = 1'b1;
        cyc(1'b1, gen_bit() ^ 1'b1, 1'b0);
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_pulse",  32'(err_pulse), 32'd0);
        chk("t6_rst_count",  32'(err_count), 32'd0);
        chk("t6_rst_state",  32'(state_o), 32'd0);
        rst = 1'b0;
        beat(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
